multicycle_controller: RTL and testbench

Control FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified instruction/data memory port and a single register-file write port, reused across several cycles per instruction. Decodes `opcode` and steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable in the datapath, and stalls on a memory ready handshake. Replaces the single-cycle decoder path when the core is built in multicycle mode.

---
 rtl/multicycle_controller.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the shared multicycle RV32I datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives every select and enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] immediate_control,
  output logic       instr_retired,
  output logic       halted,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR_ADR = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t state, next_state;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (reset) begin
      next_state = S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) next_state = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = S_EXEC_R;
            OP_I:         next_state = S_EXEC_I;
            OP_B:         next_state = S_BRANCH;
            OP_JAL:       next_state = S_JUMP;
            OP_JALR:      next_state = S_JALR_ADR;
            OP_LUI:       next_state = S_LUI;
            OP_AUIPC:     next_state = S_ALUWB;
            default:      next_state = S_ILLEGAL;
          endcase
        end
        // IR is only loaded in FETCH, so opcode is still valid here.
        S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
        S_MEMWB:    next_state = S_FETCH;
        S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
        S_EXEC_R:   next_state = S_ALUWB;
        S_EXEC_I:   next_state = S_ALUWB;
        S_ALUWB:    next_state = S_FETCH;
        S_BRANCH:   next_state = S_FETCH;
        S_JUMP:     next_state = S_ALUWB;
        S_JALR_ADR: next_state = S_JUMP;
        S_LUI:      next_state = S_ALUWB;
        S_ILLEGAL:  next_state = S_ILLEGAL;
        default:    next_state = S_ILLEGAL;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write          = 1'b0;
    ir_write          = 1'b0;
    adr_src           = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    reg_write         = 1'b0;
    alu_src_a         = 2'b00;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    result_src        = 2'b00;
    immediate_control = 3'b000;
    instr_retired     = 1'b0;
    halted            = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            OP_B:     immediate_control = 3'b010;
            OP_JAL:   immediate_control = 3'b011;
            OP_AUIPC: immediate_control = 3'b100;
            default:  immediate_control = 3'b000;
          endcase
        end
        S_MEMADR: begin
          alu_src_a         = 2'b10;
          alu_src_b         = 2'b01;
          immediate_control = (opcode == OP_SW) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          adr_src  = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          result_src    = 2'b01;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src       = 1'b1;
          mem_write     = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b10;
          alu_op        = 2'b01;
          pc_write      = branch_taken;
          instr_retired = 1'b1;
        end
        // Target was precomputed into alu_out in DECODE; ALU forms the link value.
        S_JUMP: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR_ADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_LUI: begin
          alu_src_a         = 2'b11;
          alu_src_b         = 2'b01;
          immediate_control = 3'b100;
        end
        S_ILLEGAL: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: hand-computed state sequences,
// control flags and selects per cycle, including waits, reset and ILLEGAL.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] immediate_control;
  logic       instr_retired, halted;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src),
    .immediate_control(immediate_control), .instr_retired(instr_retired),
    .halted(halted), .state_dbg(state_dbg)
  );

  // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, instr_retired, halted}
  wire [7:0]  flags = {pc_write, ir_write, adr_src, mem_read, mem_write,
                       reg_write, instr_retired, halted};
  // {alu_src_a, alu_src_b, alu_op, result_src, immediate_control}
  wire [10:0] sels  = {alu_src_a, alu_src_b, alu_op, result_src, immediate_control};

  localparam logic [7:0] F_FETCH = 8'b1101_0000;
  localparam logic [7:0] F_WAITF = 8'b0001_0000;
  localparam logic [7:0] F_NONE  = 8'b0000_0000;
  localparam logic [7:0] F_WB    = 8'b0000_0110;
  localparam logic [7:0] F_MRD   = 8'b0011_0000;
  localparam logic [7:0] F_MWR   = 8'b0010_1000;
  localparam logic [7:0] F_MWR_D = 8'b0010_1010;
  localparam logic [7:0] F_BR_T  = 8'b1000_0010;
  localparam logic [7:0] F_BR_N  = 8'b0000_0010;
  localparam logic [7:0] F_JUMP  = 8'b1000_0000;
  localparam logic [7:0] F_HALT  = 8'b0000_0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive handshake inputs, check one cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic ready, input logic taken,
                     input logic [3:0] st, input logic [7:0] fl,
                     input logic chk_sel, input logic [10:0] sel);
    mem_ready    = ready;
    branch_taken = taken;
    #1;
    check({tag, "/state"}, 32'(state_dbg), 32'(st));
    check({tag, "/flags"}, 32'(flags), 32'(fl));
    if (chk_sel) check({tag, "/sel"}, 32'(sels), 32'(sel));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = 7'b0110011; mem_ready = 1'b0; branch_taken = 1'b0;

    // Reset held three cycles: everything forced low
    for (int i = 0; i < 3; i++) begin
      #1;
      check("reset/flags", 32'(flags), 32'(F_NONE));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // ADD: 0,1,6,8 then back to FETCH
    cyc("add_f",  1, 0, 4'd0, F_FETCH, 1, 11'b00_10_00_10_000);
    cyc("add_d",  1, 0, 4'd1, F_NONE,  1, 11'b01_01_00_00_000);
    cyc("add_x",  1, 0, 4'd6, F_NONE,  1, 11'b10_00_10_00_000);
    cyc("add_wb", 1, 0, 4'd8, F_WB,    1, 11'b00_00_00_00_000);

    // LW with two MEMREAD wait cycles
    opcode = 7'b0000011;
    cyc("lw_f",   1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("lw_d",   0, 0, 4'd1, F_NONE,  0, '0);
    cyc("lw_a",   1, 0, 4'd2, F_NONE,  1, 11'b10_01_00_00_000);
    cyc("lw_w1",  0, 0, 4'd3, F_MRD,   0, '0);
    cyc("lw_w2",  0, 0, 4'd3, F_MRD,   0, '0);
    cyc("lw_r",   1, 0, 4'd3, F_MRD,   0, '0);
    cyc("lw_wb",  1, 0, 4'd4, F_WB,    1, 11'b00_00_00_01_000);

    // BEQ taken, then BEQ not taken (branch_taken outside BRANCH is ignored)
    opcode = 7'b1100011;
    cyc("bt_f",   1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("bt_d",   1, 0, 4'd1, F_NONE,  1, 11'b01_01_00_00_010);
    cyc("bt_b",   1, 1, 4'd9, F_BR_T,  1, 11'b10_00_01_00_000);
    cyc("bn_f",   1, 1, 4'd0, F_FETCH, 0, '0);
    cyc("bn_d",   1, 1, 4'd1, F_NONE,  0, '0);
    cyc("bn_b",   1, 0, 4'd9, F_BR_N,  0, '0);

    // JALR: 0,1,11,10,8
    opcode = 7'b1100111;
    cyc("jr_f",   1, 0, 4'd0,  F_FETCH, 0, '0);
    cyc("jr_d",   1, 0, 4'd1,  F_NONE,  1, 11'b01_01_00_00_000);
    cyc("jr_a",   1, 0, 4'd11, F_NONE,  1, 11'b10_01_00_00_000);
    cyc("jr_j",   1, 0, 4'd10, F_JUMP,  1, 11'b01_10_00_00_000);
    cyc("jr_wb",  1, 0, 4'd8,  F_WB,    0, '0);

    // JAL: 0,1,10,8 with J immediate in DECODE
    opcode = 7'b1101111;
    cyc("jal_f",  1, 0, 4'd0,  F_FETCH, 0, '0);
    cyc("jal_d",  1, 0, 4'd1,  F_NONE,  1, 11'b01_01_00_00_011);
    cyc("jal_j",  1, 0, 4'd10, F_JUMP,  0, '0);
    cyc("jal_wb", 1, 0, 4'd8,  F_WB,    0, '0);

    // LUI: 0,1,12,8
    opcode = 7'b0110111;
    cyc("lui_f",  1, 0, 4'd0,  F_FETCH, 0, '0);
    cyc("lui_d",  1, 0, 4'd1,  F_NONE,  0, '0);
    cyc("lui_x",  1, 0, 4'd12, F_NONE,  1, 11'b11_01_00_00_100);
    cyc("lui_wb", 1, 0, 4'd8,  F_WB,    0, '0);

    // AUIPC: 0,1,8 with U immediate in DECODE
    opcode = 7'b0010111;
    cyc("aui_f",  1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("aui_d",  1, 0, 4'd1, F_NONE,  1, 11'b01_01_00_00_100);
    cyc("aui_wb", 1, 0, 4'd8, F_WB,    0, '0);

    // SW with one MEMWRITE wait, I-type ALU with a FETCH wait
    opcode = 7'b0100011;
    cyc("sw_f",   1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("sw_d",   1, 0, 4'd1, F_NONE,  0, '0);
    cyc("sw_a",   1, 0, 4'd2, F_NONE,  1, 11'b10_01_00_00_001);
    cyc("sw_w",   0, 0, 4'd5, F_MWR,   0, '0);
    cyc("sw_done",1, 0, 4'd5, F_MWR_D, 0, '0);
    opcode = 7'b0010011;
    cyc("i_fw",   0, 0, 4'd0, F_WAITF, 0, '0);
    cyc("i_f",    1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("i_d",    1, 0, 4'd1, F_NONE,  0, '0);
    cyc("i_x",    1, 0, 4'd7, F_NONE,  1, 11'b10_01_10_00_000);
    cyc("i_wb",   1, 0, 4'd8, F_WB,    0, '0);

    // Illegal opcode: sticky halt for 10 cycles, cleared only by reset
    opcode = 7'b0000000;
    cyc("ill_f",  1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("ill_d",  1, 0, 4'd1, F_NONE,  0, '0);
    for (int i = 0; i < 10; i++) cyc("ill_h", 1, 1, 4'd15, F_HALT, 0, '0);
    reset = 1'b1;
    #1;
    check("ill_rst/flags", 32'(flags), 32'(F_NONE));
    @(posedge clk);
    #1;
    check("ill_rst/state", 32'(state_dbg), 32'(4'd0));
    reset = 1'b0;
    cyc("post_ill_f", 1, 0, 4'd0, F_FETCH, 0, '0);

    // Reset during a MEMWRITE wait abandons the store
    opcode = 7'b0100011;
    cyc("swr_d",  1, 0, 4'd1, F_NONE,  0, '0);
    cyc("swr_a",  1, 0, 4'd2, F_NONE,  0, '0);
    mem_ready = 1'b0;
    #1;
    check("swr_w/flags", 32'(flags), 32'(F_MWR));
    reset = 1'b1;
    #1;
    check("swr_rst/flags", 32'(flags), 32'(F_NONE));
    @(posedge clk);
    #1;
    check("swr_next/state", 32'(state_dbg), 32'(4'd0));
    check("swr_next/flags", 32'(flags), 32'(F_NONE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("swr_fw", 0, 0, 4'd0, F_WAITF, 0, '0);
    cyc("swr_f",  1, 0, 4'd0, F_FETCH, 0, '0);
    cyc("swr_d2", 1, 0, 4'd1, F_NONE,  0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
